// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: grants whole SPI bursts round-robin to N_REQ requesters, owns the chip selects
// and sequences spi_master start/busy per byte. Optional per-byte timeout: define SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int N_REQ       = 2,
    parameter int CS_SETUP    = 4,
    parameter int CS_HOLD     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   byte_valid,
    input  logic [8*N_REQ-1:0] byte_in,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   byte_done,
    output logic [7:0]         rx_byte,
    output logic [N_REQ-1:0]   ss_n,
    output logic               m_start,
    output logic [7:0]         m_data_in,
    input  logic               m_busy,
    input  logic [7:0]         m_data_out,
    output logic               fault
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] READY = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] XFER  = 3'd4;
    localparam logic [2:0] HOLD  = 3'd5;

    localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    // SETUP, READY and START together span CS_SETUP cycles from ss_n falling to m_start.
    localparam int SETUP_LAST_I = (CS_SETUP >= 3) ? CS_SETUP - 3 : 0;
    localparam int HOLD_REL_I   = CS_HOLD - 1;
    localparam int HOLD_END_I   = 2 * CS_HOLD - 2;
    localparam int BASE_MAX_I   = (HOLD_END_I > SETUP_LAST_I) ? HOLD_END_I : SETUP_LAST_I;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_MAX_I    = (TIMEOUT_CYC - 1 > BASE_MAX_I) ? TIMEOUT_CYC - 1 : BASE_MAX_I;
`else
    localparam int CNT_MAX_I    = BASE_MAX_I;
`endif
    localparam int CW = (CNT_MAX_I > 1) ? $clog2(CNT_MAX_I + 1) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_LAST_I);
    localparam logic [CW-1:0] HOLD_REL   = CW'(HOLD_REL_I);
    localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_END_I);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TOUT_LAST  = CW'(TIMEOUT_CYC - 1);
`endif
    localparam logic [PW:0]   NREQ_W     = (PW + 1)'(N_REQ);
    localparam logic [PW-1:0] LAST_IDX   = PW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 4 || CS_SETUP < 3 || CS_HOLD < 2 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("spi_bus_arbiter: unsupported parameter set");
    end

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [PW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [2:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    owner_r;
    logic             busy_seen_r;
    logic [N_REQ-1:0] grant_r;
    logic [N_REQ-1:0] ss_n_r;
    logic [N_REQ-1:0] byte_done_r;
    logic [7:0]       rx_byte_r;
    logic             m_start_r;
    logic [7:0]       m_data_in_r;
`ifdef SPI_ARB_TIMEOUT_EN
    logic             fault_r;
`endif

    logic [PW:0]      sum_s;
    logic [PW-1:0]    cand_s;
    logic [PW-1:0]    win_idx_s;
    logic             win_found_s;

    // Round-robin pick: lowest offset from the pointer wins, so scan offsets high to low.
    always_comb begin
        sum_s       = '0;
        cand_s      = '0;
        win_idx_s   = '0;
        win_found_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum_s  = {1'b0, ptr_r} + (PW + 1)'(k);
            cand_s = (sum_s >= NREQ_W) ? PW'(sum_s - NREQ_W) : sum_s[PW-1:0];
            if (req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Burst / byte sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            ptr_r       <= '0;
            owner_r     <= '0;
            busy_seen_r <= 1'b0;
            grant_r     <= '0;
            ss_n_r      <= '1;
            byte_done_r <= '0;
            rx_byte_r   <= 8'h00;
            m_start_r   <= 1'b0;
            m_data_in_r <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
            fault_r     <= 1'b0;
`endif
        end else begin
            byte_done_r <= '0;
            m_start_r   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            fault_r     <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        owner_r <= win_idx_s;
                        grant_r <= idx_onehot(win_idx_s);
                        ss_n_r  <= ~idx_onehot(win_idx_s);
                        cnt_r   <= '0;
                        state_r <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r   <= '0;
                        state_r <= READY;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                READY: begin
                    if (!req[owner_r]) begin
                        cnt_r   <= '0;
                        state_r <= HOLD;
                    end else if (byte_valid[owner_r]) begin
                        m_data_in_r <= byte_in[{owner_r, 3'b000} +: 8];
                        state_r     <= START;
                    end
                end
                START: begin
                    m_start_r   <= 1'b1;
                    busy_seen_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= XFER;
                end
                XFER: begin
                    if (busy_seen_r && !m_busy) begin
                        rx_byte_r   <= m_data_out;
                        byte_done_r <= idx_onehot(owner_r);
                        cnt_r       <= '0;
                        state_r     <= req[owner_r] ? READY : HOLD;
`ifdef SPI_ARB_TIMEOUT_EN
                    end else if (cnt_r == TOUT_LAST) begin
                        fault_r <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= HOLD;
`endif
                    end else begin
                        busy_seen_r <= busy_seen_r | m_busy;
`ifdef SPI_ARB_TIMEOUT_EN
                        cnt_r       <= cnt_r + CNT_ONE;
`endif
                    end
                end
                HOLD: begin
                    // First half keeps ss_n low, second half enforces the minimum ss_n high gap.
                    if (cnt_r == HOLD_REL) begin
                        ss_n_r  <= '1;
                        grant_r <= '0;
                        ptr_r   <= (owner_r == LAST_IDX) ? '0 : owner_r + PW'(1);
                        cnt_r   <= cnt_r + CNT_ONE;
                    end else if (cnt_r == HOLD_END) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    grant_r <= '0;
                    ss_n_r  <= '1;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign ss_n      = ss_n_r;
    assign byte_done = byte_done_r;
    assign rx_byte   = rx_byte_r;
    assign m_start   = m_start_r;
    assign m_data_in = m_data_in_r;
`ifdef SPI_ARB_TIMEOUT_EN
    assign fault     = fault_r;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter (N_REQ=2, CS_SETUP=CS_HOLD=4, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spi_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  byte_valid;
    logic [15:0] byte_in;
    logic [1:0]  grant;
    logic [1:0]  byte_done;
    logic [7:0]  rx_byte;
    logic [1:0]  ss_n;
    logic        m_start;
    logic [7:0]  m_data_in;
    logic        m_busy;
    logic [7:0]  m_data_out;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    spi_bus_arbiter #(
        .N_REQ       (2),
        .CS_SETUP    (4),
        .CS_HOLD     (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .grant      (grant),
        .byte_done  (byte_done),
        .rx_byte    (rx_byte),
        .ss_n       (ss_n),
        .m_start    (m_start),
        .m_data_in  (m_data_in),
        .m_busy     (m_busy),
        .m_data_out (m_data_out),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte from READY: byte_valid, m_start two cycles later, slave busy two cycles, byte_done.
    task automatic xfer_byte(input int idx, input logic [7:0] tx, input logic [7:0] rx,
                             input bit stray, input bit drop);
        logic [1:0] oh;
        oh = 2'b01 << idx;
        byte_valid = oh;
        byte_in[8*idx +: 8] = tx;
        tick();
        byte_valid = 2'b00;
        check("start_not_early", m_start, 1'b0);
        check("data_latched", m_data_in, tx);
        tick();
        check("m_start_pulse", m_start, 1'b1);
        m_busy = 1'b1;
        if (drop) req[idx] = 1'b0;
        tick();
        check("m_start_one_cycle", m_start, 1'b0);
        if (stray) begin
            byte_valid = oh;
            byte_in[8*idx +: 8] = 8'h99;
        end
        tick();
        byte_valid = 2'b00;
        check("no_start_in_xfer", m_start, 1'b0);
        check("data_stable", m_data_in, tx);
        check("no_early_done", byte_done, 2'b00);
        m_busy = 1'b0;
        m_data_out = rx;
        tick();
        check("byte_done", byte_done, oh);
        check("rx_byte", rx_byte, rx);
        check("no_start_after_done", m_start, 1'b0);
        if (stray) begin
            tick();
            check("stray_ignored_a", m_start, 1'b0);
            tick();
            check("stray_ignored_b", m_start, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; byte_valid = 2'b00; byte_in = 16'h0000;
        m_busy = 1'b0; m_data_out = 8'h00;
        tick(); tick();
        check("rst_grant", grant, 2'b00);
        check("rst_ss_n", ss_n, 2'b11);
        check("rst_byte_done", byte_done, 2'b00);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_m_start", m_start, 1'b0);
        check("rst_m_data_in", m_data_in, 8'h00);
        check("rst_fault", fault, 1'b0);
        rst = 1'b1;
        tick();
        check("idle_no_grant", grant, 2'b00);

        // Single burst on requester 0
        req = 2'b01;
        tick();
        check("burst_grant", grant, 2'b01);
        check("burst_ss_n", ss_n, 2'b10);
        tick();
        check("setup_no_start_a", m_start, 1'b0);
        tick();
        check("setup_no_start_b", m_start, 1'b0);
        xfer_byte(0, 8'hA5, 8'h11, 1'b0, 1'b0);
        xfer_byte(0, 8'h3C, 8'h22, 1'b0, 1'b0);
        xfer_byte(0, 8'hFF, 8'h33, 1'b0, 1'b0);
        req = 2'b00;
        repeat (4) tick();
        check("hold_ss_n_low", ss_n, 2'b10);
        tick();
        check("release_ss_n", ss_n, 2'b11);
        check("release_grant", grant, 2'b00);
        repeat (3) tick();

        // Reset asserted mid-XFER
        req = 2'b01;
        tick();
        check("mr_grant", grant, 2'b01);
        tick(); tick();
        byte_valid = 2'b01; byte_in[7:0] = 8'h42;
        tick();
        byte_valid = 2'b00;
        tick();
        check("mr_m_start", m_start, 1'b1);
        m_busy = 1'b1;
        rst = 1'b0;
        #1;
        check("mr_ss_n", ss_n, 2'b11);
        check("mr_grant_clr", grant, 2'b00);
        check("mr_m_start_clr", m_start, 1'b0);
        check("mr_m_data_in_clr", m_data_in, 8'h00);
        tick();
        m_busy = 1'b0; m_data_out = 8'hEE;
        tick();
        req = 2'b00; rst = 1'b1;
        tick();
        check("mr_no_done_a", byte_done, 2'b00);
        check("mr_rx_byte", rx_byte, 8'h00);
        tick();
        check("mr_no_done_b", byte_done, 2'b00);
        check("mr_ss_n_idle", ss_n, 2'b11);

        // Contention: pointer is 0 after reset
        req = 2'b11;
        tick();
        check("cont_grant0", grant, 2'b01);
        check("cont_ss_n0", ss_n, 2'b10);
        tick(); tick();
        byte_valid = 2'b10; byte_in[15:8] = 8'hEE;
        tick();
        byte_valid = 2'b00;
        check("nonowner_ignored_a", m_start, 1'b0);
        tick();
        check("nonowner_ignored_b", m_start, 1'b0);
        check("nonowner_no_latch", m_data_in, 8'h00);
        xfer_byte(0, 8'h5A, 8'h21, 1'b0, 1'b0);
        xfer_byte(0, 8'hC3, 8'h44, 1'b1, 1'b0);
        req = 2'b10;
        repeat (4) tick();
        check("cont_hold_grant", grant, 2'b01);
        check("cont_hold_ss_n", ss_n, 2'b10);
        tick();
        check("cont_gap_grant", grant, 2'b00);
        check("cont_gap_ss_n", ss_n, 2'b11);
        repeat (3) tick();
        check("cont_gap_end_grant", grant, 2'b00);
        check("cont_gap_end_ss_n", ss_n, 2'b11);
        tick();
        check("cont_grant1", grant, 2'b10);
        check("cont_ss_n1", ss_n, 2'b01);
        tick(); tick();
        xfer_byte(1, 8'h81, 8'h5A, 1'b0, 1'b0);
        req = 2'b00;
        repeat (8) tick();
        check("rr_idle_ss_n", ss_n, 2'b11);

        // Round-robin returns to requester 0, then early release mid-byte
        req = 2'b11;
        tick();
        check("rr_grant0", grant, 2'b01);
        tick(); tick();
        xfer_byte(0, 8'h3C, 8'h77, 1'b0, 1'b1);
        repeat (3) tick();
        check("early_ss_n_low", ss_n, 2'b10);
        check("early_grant_kept", grant, 2'b01);
        tick();
        check("early_ss_n_high", ss_n, 2'b11);
        check("early_grant_clr", grant, 2'b00);
        repeat (3) tick();
        check("early_gap_grant", grant, 2'b00);
        tick();
        check("early_next_grant", grant, 2'b10);
        check("early_next_ss_n", ss_n, 2'b01);
        req = 2'b00;
        repeat (12) tick();
        check("empty_burst_ss_n", ss_n, 2'b11);
        check("empty_burst_grant", grant, 2'b00);

        // Stuck m_busy
        req = 2'b01;
        tick();
        check("to_grant", grant, 2'b01);
        tick(); tick();
        byte_valid = 2'b01; byte_in[7:0] = 8'h55;
        tick();
        byte_valid = 2'b00;
        tick();
        check("to_m_start", m_start, 1'b1);
        m_busy = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (15) tick();
        check("to_no_fault_yet", fault, 1'b0);
        tick();
        check("to_fault", fault, 1'b1);
        check("to_no_done", byte_done, 2'b00);
        tick();
        check("to_fault_one_cycle", fault, 1'b0);
        repeat (2) tick();
        check("to_ss_n_held", ss_n, 2'b10);
        tick();
        check("to_ss_n_released", ss_n, 2'b11);
        check("to_grant_released", grant, 2'b00);
        m_busy = 1'b0;
        req = 2'b00;
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            check("hang_no_fault", fault, 1'b0);
            check("hang_no_done", byte_done, 2'b00);
        end
        check("hang_ss_n", ss_n, 2'b10);
        check("hang_grant", grant, 2'b01);
        m_busy = 1'b0; m_data_out = 8'h66;
        tick();
        check("hang_late_done", byte_done, 2'b01);
        check("hang_late_rx", rx_byte, 8'h66);
        req = 2'b00;
`endif
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
